sine_lut_ram: RTL and testbench
===============================

// Module: sine_lut_ram
// PURPOSE
//  Write-port responder and read port for the NCO sine look-up table.
//  - Accepts table writes on the port-0 SRAM-style interface (csb0/addr0/din0) driven by the init sequencer.
//  - Serves registered reads to the phase accumulator.
//  - Tracks which entries are loaded and flags a complete table; the NCO starts stepping only once the table is complete.
// PARAMETERS
//  ADDR_W   8    table address width
//  DATA_W   16   sample width (signed Q1.15)
//  DEPTH    256  entries; must equal 2**ADDR_W
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  csb0       in   1       write chip select, active-low
//  addr0      in   ADDR_W  write address
//  din0       in   DATA_W  write data
//  rd_en      in   1       read request
//  rd_addr    in   ADDR_W  read address (phase)
//  rd_data    out  DATA_W  read data
//  rd_valid   out  1       rd_data valid
//  wr_count   out  ADDR_W+1  number of distinct entries written
//  table_full out  1       all DEPTH entries written
//  wr_err     out  1       sticky protection error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=0, async): rd_data=0, rd_valid=0, wr_count=0, table_full=0, wr_err=0, written-map cleared.
//    Array contents are not reset.
//  - Write: at a rising edge with csb0=0, mem[addr0] <= din0.
//    - If written[addr0]=0: set it and increment wr_count.
//    - Rewriting the same address updates data only; wr_count is unchanged.
//  - table_full is registered: high in the cycle after wr_count reaches DEPTH. It stays high until reset.
//  - Read latency is 1 cycle: rd_en=1 at edge N -> rd_data/rd_valid at edge N+1.
//    - rd_valid=0 when rd_en=0. rd_data holds its last value when rd_en=0.
//    - If written[rd_addr]=0, rd_data=0 (never X).
//  - Read/write collision (same address, same edge): read-before-write; rd_data returns the old contents.
//    - An unwritten address returns 0 in that case.
//  - Back-to-back reads every cycle are supported at full throughput, with no bubbles.
//  - wr_count saturates at DEPTH and never wraps. Address wrap is implicit in ADDR_W.
//  - Reset asserted mid-load clears the map and count. Entries must be reloaded before table_full asserts again.
// CONFIGURATION
//  WRITE_PROTECT_EN
//  - Defined:
//    - While table_full=1, writes are ignored and the array is unchanged.
//    - Any csb0=0 cycle sets wr_err; wr_err stays set until reset.
//  - Undefined:
//    - Writes are always accepted, including rewrites after full.
//    - wr_err is tied to 0.
// STRUCTURE
//  - Package sine_lut_pkg:
//    - Constants LUT_ADDR_W=8, LUT_DATA_W=16, LUT_DEPTH=256.
//    - Typedefs lut_addr_t, lut_sample_t, lut_count_t (ADDR_W+1 bits).
//    - The NCO and the init sequencer share this package.
//  - Sub-module sine_lut_array:
//    - Plain DEPTH x DATA_W synchronous array, one write port, one registered read port, read-before-write.
//    - Isolated so it can later be swapped for a hard SRAM macro.
//  - The top level holds the written-map, counter, flags and the zero-masking of unwritten reads.
// TESTING
//  1. Reset, then read addr 0x10 with rd_en=1 -> next cycle rd_valid=1, rd_data=0x0000; wr_count=0.
//  2. Write addr 0x40=0x7FFF, read 0x40 the next cycle -> rd_data=0x7FFF; wr_count=1.
//     Rewrite 0x40=0x1234 -> wr_count stays 1.
//  3. Write all 256 sine entries in order (csb0=0 for 256 cycles) -> wr_count=256.
//     - table_full rises 1 cycle after the last write.
//     - Sweep reads 0..255 back-to-back -> each matches the table, rd_valid high continuously.
//  4. Collision: mem[0x05]=0xAAAA; write 0x05=0x5555 and read 0x05 on the same edge
//     -> rd_data=0xAAAA, then a read on the next edge -> 0x5555.
//  5. Assert rst low after 100 writes, mid-load -> all outputs 0 immediately (async).
//     - After rst returns high, a read of addr 3 -> rd_data=0.
//  6. WRITE_PROTECT_EN defined, table full: write 0x00=0xFFFF -> wr_err=1, read 0x00 returns the original value.
//     Macro undefined: the write lands and wr_err stays 0.

Source files
------------

// File: rtl/sine_lut_pkg.sv
// Shared definitions for the NCO sine look-up table.
// Used by the LUT RAM, the NCO phase accumulator and the init sequencer.
//   LUT_ADDR_W / LUT_DATA_W / LUT_DEPTH : table geometry (256 x Q1.15)
//   lut_addr_t   : table index / phase
//   lut_sample_t : signed Q1.15 sample
//   lut_count_t  : entry count, one bit wider than the address so it can hold DEPTH
package sine_lut_pkg;

  localparam int LUT_ADDR_W = 8;
  localparam int LUT_DATA_W = 16;
  localparam int LUT_DEPTH  = 256;

  typedef logic        [LUT_ADDR_W-1:0] lut_addr_t;
  typedef logic signed [LUT_DATA_W-1:0] lut_sample_t;
  typedef logic        [LUT_ADDR_W:0]   lut_count_t;

endpackage

// File: rtl/sine_lut_array.sv
// Plain DEPTH x DATA_W synchronous storage for the sine table.
// One write port, one registered read port, read-before-write on a
// same-address collision. Kept free of reset and masking logic so it can be
// replaced by a hard SRAM macro with the same timing.
// Ports:
//   clk      : rising-edge clock
//   we       : write enable (active-high)
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable; output register holds when low
//   rd_addr  : read address
//   rd_data  : registered read data (1-cycle latency)
module sine_lut_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic        [ADDR_W-1:0] wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic        [ADDR_W-1:0] rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rd_data_p1;

  // Stage p1: both ports sample on the same edge; the non-blocking write means
  // a colliding read picks up the previous contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_p1 <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_p1;

endmodule

// File: rtl/sine_lut_ram.sv
// Sine LUT RAM for the NCO: accepts table writes from the init sequencer on an
// SRAM-style port (csb0/addr0/din0), serves 1-cycle registered reads to the
// phase accumulator, and tracks which entries have been loaded so the NCO can
// wait for a complete table.
// Optional feature macro: WRITE_PROTECT_EN
//   defined   : writes ignored once table_full is set; a write attempt then
//               sets the sticky wr_err flag
//   undefined : writes always accepted, wr_err tied low
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   csb0       : write chip select, active-low
//   addr0      : write address
//   din0       : write data (Q1.15)
//   rd_en      : read request
//   rd_addr    : read address (phase)
//   rd_data    : read data, 0 for never-written entries
//   rd_valid   : rd_data valid, one cycle after rd_en
//   wr_count   : number of distinct entries written (saturates at DEPTH)
//   table_full : all DEPTH entries written, sticky until reset
//   wr_err     : sticky write-protection error
module sine_lut_ram
  import sine_lut_pkg::*;
#(
  parameter int ADDR_W = LUT_ADDR_W,
  parameter int DATA_W = LUT_DATA_W,
  parameter int DEPTH  = LUT_DEPTH   // must equal 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     csb0,
  input  logic        [ADDR_W-1:0] addr0,
  input  logic signed [DATA_W-1:0] din0,
  input  logic                     rd_en,
  input  logic        [ADDR_W-1:0] rd_addr,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_valid,
  output logic        [ADDR_W:0]   wr_count,
  output logic                     table_full,
  output logic                     wr_err
);

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

  logic                     wr_accept;
  logic [DEPTH-1:0]         written;
  logic                     hit_p1;
  logic                     vld_p1;
  logic signed [DATA_W-1:0] arr_rd_data;

`ifdef WRITE_PROTECT_EN
  assign wr_accept = ~csb0 & ~table_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
    end else if (~csb0 & table_full) begin
      wr_err <= 1'b1;
    end
  end
`else
  assign wr_accept = ~csb0;
  assign wr_err    = 1'b0;
`endif

  sine_lut_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (wr_accept),
    .wr_addr (addr0),
    .wr_data (din0),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (arr_rd_data)
  );

  // Written-map and distinct-entry counter. A rewrite of a loaded entry leaves
  // the count alone; the explicit saturation guards against any wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      written  <= '0;
      wr_count <= '0;
    end else if (wr_accept) begin
      written[addr0] <= 1'b1;
      if (!written[addr0] && wr_count != FULL_CNT) begin
        wr_count <= wr_count + 1'b1;
      end
    end
  end

  // table_full follows the count by one cycle and is held until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      table_full <= 1'b0;
    end else if (wr_count == FULL_CNT) begin
      table_full <= 1'b1;
    end
  end

  // Stage p1: capture whether the addressed entry was loaded before this edge,
  // matching the array's read-before-write data. hit_p1 holds with the array
  // output when rd_en is low, so rd_data holds too; clearing hit_p1 on reset
  // forces rd_data to 0 immediately without resetting the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      hit_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        hit_p1 <= written[rd_addr];
      end
    end
  end

  assign rd_valid = vld_p1;
  assign rd_data  = hit_p1 ? arr_rd_data : '0;

endmodule

// File: tb/tb_sine_lut_ram.sv
module tb_sine_lut_ram;
  import sine_lut_pkg::*;

`ifdef WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        csb0;
  logic [7:0]  addr0;
  logic [15:0] din0;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [8:0]  wr_count;
  logic        table_full;
  logic        wr_err;

  always #5 clk = ~clk;

  sine_lut_ram dut (
    .clk        (clk),
    .rst        (rst),
    .csb0       (csb0),
    .addr0      (addr0),
    .din0       (din0),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .wr_count   (wr_count),
    .table_full (table_full),
    .wr_err     (wr_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: table contents, loaded flags and expected outputs.
  logic [15:0] m_mem [256];
  bit          m_wr  [256];
  int          m_count;
  bit          m_full;
  bit          m_err;
  logic [15:0] m_rd;
  bit          m_vld;
  logic [15:0] sine  [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rd_valid"},   32'(rd_valid),   32'(m_vld));
    check({tag, ".rd_data"},    32'(rd_data),    32'(m_rd));
    check({tag, ".wr_count"},   32'(wr_count),   32'(m_count));
    check({tag, ".table_full"}, 32'(table_full), 32'(m_full));
    check({tag, ".wr_err"},     32'(wr_err),     32'(m_err));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
    m_count = 0;
    m_full  = 1'b0;
    m_err   = 1'b0;
    m_rd    = '0;
    m_vld   = 1'b0;
  endtask

  // One clock cycle: drive inputs, let the edge happen, advance the model,
  // then compare all outputs 1 time unit after the edge.
  task automatic step(input bit cs, input logic [7:0] wa, input logic [15:0] wd,
                      input bit re, input logic [7:0] ra, input string tag);
    bit nxt_full;
    csb0 = cs; addr0 = wa; din0 = wd; rd_en = re; rd_addr = ra;
    @(posedge clk);
    // Reads observe the table as it was before this edge.
    if (re) m_rd = m_wr[ra] ? m_mem[ra] : 16'h0000;
    m_vld    = re;
    nxt_full = m_full || (m_count == 256);
    if (!cs) begin
      if (WP && m_full) begin
        m_err = 1'b1;
      end else begin
        m_mem[wa] = wd;
        if (!m_wr[wa]) begin
          m_wr[wa] = 1'b1;
          if (m_count < 256) m_count++;
        end
      end
    end
    m_full = nxt_full;
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++)
      sine[i] = 16'($rtoi(32767.0 * $sin(6.283185307179586 * i / 256.0)));

    rst = 1'b0; csb0 = 1'b1; addr0 = '0; din0 = '0; rd_en = 1'b0; rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // Read of an unwritten entry returns zero.
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h10, "t1_rd_unwritten");

    // Single write, read back, rewrite keeps count.
    step(1'b0, 8'h40, 16'h7FFF, 1'b0, 8'h00, "t2_wr");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h40, "t2_rd");
    step(1'b0, 8'h40, 16'h1234, 1'b0, 8'h00, "t2_rewrite");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h40, "t2_rd_rewrite");

    // Collision on an unwritten entry returns zero, then the new data.
    step(1'b0, 8'h07, 16'h1111, 1'b1, 8'h07, "coll_unwritten");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h07, "coll_unwritten_next");

    // Partial random load, then asynchronous reset between clock edges.
    for (int i = 0; i < 100; i++)
      step(1'b0, 8'(i), 16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), "t5_load");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h02, "t5_rd_before_rst");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("t5_async_rst");
    @(posedge clk);
    #1;
    check_all("t5_in_rst");
    rst = 1'b1;
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h03, "t5_rd3_after_rst");

    // Full sine load; table_full one cycle after the last write.
    for (int i = 0; i < 256; i++)
      step(1'b0, 8'(i), sine[i], 1'b0, 8'h00, "t3_load");
    step(1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, "t3_full");
    for (int i = 0; i < 256; i++)
      step(1'b1, 8'h00, 16'h0000, 1'b1, 8'(i), "t3_sweep");

    // Read-before-write collision on a loaded entry.
    step(1'b0, 8'h05, 16'hAAAA, 1'b0, 8'h00, "t4_setup");
    step(1'b0, 8'h05, 16'h5555, 1'b1, 8'h05, "t4_coll");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h05, "t4_next");

    // Write after full: protected or accepted depending on build.
    step(1'b0, 8'h00, 16'hFFFF, 1'b0, 8'h00, "t6_wr_after_full");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'h00, "t6_rd");

    // Random traffic, then an idle cycle to confirm rd_data holds.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 8'($urandom), "rand");
    step(1'b1, 8'h00, 16'h0000, 1'b1, 8'($urandom), "hold_setup");
    step(1'b1, 8'h00, 16'h0000, 1'b0, 8'h00, "hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
